// File: rtl/envelope_pkg.sv
// Shared constants and width helpers for the multi-channel envelope tracker.
package envelope_pkg;

  localparam int unsigned BETA_SHIFT_A = 2;
  localparam int unsigned BETA_SHIFT_B = 3;

  function automatic int unsigned ch_width(input int unsigned num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

  // Accumulator holds up to mag * 2^FRAC_BITS with mag < 2^DATA_WIDTH.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned frac_bits);
    return data_w + frac_bits;
  endfunction

endpackage

// File: rtl/magnitude_approx_pipe.sv
// Stages 1-2: absolute values, then alpha-max/beta-min magnitude (alpha=1, beta=3/8).
// Samples on channels >= NUM_CH are dropped at stage 1.
module magnitude_approx_pipe
  import envelope_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CH_W       = ch_width(NUM_CH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [CH_W-1:0]       i_ch,
  input  logic [DATA_WIDTH-1:0] i_Re,
  input  logic [DATA_WIDTH-1:0] i_Im,
  output logic                  o_valid,
  output logic [CH_W-1:0]       o_ch,
  output logic [DATA_WIDTH-1:0] o_mag
);

  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  logic [DATA_WIDTH-1:0] a_abs, b_abs;
  logic                  ch_ok;

  logic                  s1_valid;
  logic [CH_W-1:0]       s1_ch;
  logic [DATA_WIDTH-1:0] s1_a, s1_b;

  logic [DATA_WIDTH-1:0] mx, mn, mag;

  // Negating the most negative code yields 2^(W-1), which is correct when read unsigned.
  always_comb begin
    a_abs = i_Re[DATA_WIDTH-1] ? -i_Re : i_Re;
    b_abs = i_Im[DATA_WIDTH-1] ? -i_Im : i_Im;
    ch_ok = ({1'b0, i_ch} < NUM_CH_L);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= i_valid && ch_ok;
      s1_ch    <= i_ch;
      s1_a     <= a_abs;
      s1_b     <= b_abs;
    end
  end

  always_comb begin
    mx  = (s1_a >= s1_b) ? s1_a : s1_b;
    mn  = (s1_a >= s1_b) ? s1_b : s1_a;
    mag = mx + (mn >> BETA_SHIFT_A) + (mn >> BETA_SHIFT_B);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_ch    <= '0;
      o_mag   <= '0;
    end else begin
      o_valid <= s1_valid;
      o_ch    <= s1_ch;
      o_mag   <= mag;
    end
  end

endmodule

// File: rtl/envelope_tracker_mc.sv
// Time-multiplexed envelope tracker: shared magnitude pipe plus per-channel attack/release integrator.
// Optional per-channel peak hold enabled by ENVELOPE_PEAK_HOLD_EN.
module envelope_tracker_mc
  import envelope_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned NUM_CH     = 4,
  parameter  int unsigned FRAC_BITS  = 8,
  parameter  int unsigned SHIFT_W    = 4,
  localparam int unsigned CH_W       = ch_width(NUM_CH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [CH_W-1:0]       i_ch,
  input  logic [DATA_WIDTH-1:0] i_Re,
  input  logic [DATA_WIDTH-1:0] i_Im,
  input  logic [SHIFT_W-1:0]    i_attack_shift,
  input  logic [SHIFT_W-1:0]    i_release_shift,
  input  logic [NUM_CH-1:0]     i_ch_clear,
  output logic                  o_valid,
  output logic [CH_W-1:0]       o_ch,
  output logic [DATA_WIDTH-1:0] o_env
`ifdef ENVELOPE_PEAK_HOLD_EN
  ,
  output logic [DATA_WIDTH-1:0] o_peak
`endif
);

  localparam int unsigned ACC_W  = acc_width(DATA_WIDTH, FRAC_BITS);
  localparam int unsigned DIFF_W = ACC_W + 1;

  logic                  m_valid;
  logic [CH_W-1:0]       m_ch;
  logic [DATA_WIDTH-1:0] m_mag;

  magnitude_approx_pipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_CH    (NUM_CH),
    .CH_W      (CH_W)
  ) u_mag (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .i_ch   (i_ch),
    .i_Re   (i_Re),
    .i_Im   (i_Im),
    .o_valid(m_valid),
    .o_ch   (m_ch),
    .o_mag  (m_mag)
  );

  logic [ACC_W-1:0]         acc [NUM_CH];
  logic [ACC_W-1:0]         acc_cur, acc_nxt;
  logic signed [DIFF_W-1:0] diff, step;
  logic [SHIFT_W-1:0]       shift;
  logic                     upd_clear;

  // Channel select is a compare loop so out-of-range codes never index past the arrays.
  always_comb begin
    acc_cur   = '0;
    upd_clear = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (m_ch == CH_W'(k)) begin
        acc_cur   = acc[k];
        upd_clear = i_ch_clear[k];
      end
    end
    diff    = $signed({1'b0, m_mag, {FRAC_BITS{1'b0}}}) - $signed({1'b0, acc_cur});
    shift   = (!diff[DIFF_W-1] && (diff != '0)) ? i_attack_shift : i_release_shift;
    step    = diff >>> shift;
    acc_nxt = acc_cur + ACC_W'(step);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < NUM_CH; k++) acc[k] <= '0;
      o_valid <= 1'b0;
      o_ch    <= '0;
      o_env   <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (i_ch_clear[k])
          acc[k] <= '0;
        else if (m_valid && (m_ch == CH_W'(k)))
          acc[k] <= acc_nxt;
      end
      o_valid <= m_valid;
      if (m_valid) begin
        o_ch  <= m_ch;
        o_env <= upd_clear ? '0 : acc_nxt[ACC_W-1:FRAC_BITS];
      end
    end
  end

`ifdef ENVELOPE_PEAK_HOLD_EN
  logic [DATA_WIDTH-1:0] peak [NUM_CH];
  logic [DATA_WIDTH-1:0] peak_cur, peak_nxt;

  always_comb begin
    peak_cur = '0;
    for (int unsigned k = 0; k < NUM_CH; k++)
      if (m_ch == CH_W'(k)) peak_cur = peak[k];
    peak_nxt = (m_mag > peak_cur) ? m_mag : peak_cur;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < NUM_CH; k++) peak[k] <= '0;
      o_peak <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (i_ch_clear[k])
          peak[k] <= '0;
        else if (m_valid && (m_ch == CH_W'(k)))
          peak[k] <= peak_nxt;
      end
      if (m_valid) o_peak <= upd_clear ? '0 : peak_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_envelope_tracker_mc.sv
// Directed self-checking bench for envelope_tracker_mc (optionally with ENVELOPE_PEAK_HOLD_EN).
module tb_envelope_tracker_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [1:0]  ch;
  logic [15:0] re, im;
  logic [3:0]  atk, rel;
  logic [3:0]  clr;
  logic        ov;
  logic [1:0]  och;
  logic [15:0] oenv;

  // Second instance with NUM_CH=3 so that an out-of-range channel code is representable.
  logic        valid2;
  logic [1:0]  ch2;
  logic [2:0]  clr2;
  logic        ov2;
  logic [1:0]  och2;
  logic [15:0] oenv2;

`ifdef ENVELOPE_PEAK_HOLD_EN
  logic [15:0] opeak, opeak2;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  envelope_tracker_mc #(.DATA_WIDTH(16), .NUM_CH(4), .FRAC_BITS(8), .SHIFT_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_ch(ch), .i_Re(re), .i_Im(im),
    .i_attack_shift(atk), .i_release_shift(rel), .i_ch_clear(clr),
    .o_valid(ov), .o_ch(och), .o_env(oenv)
`ifdef ENVELOPE_PEAK_HOLD_EN
    , .o_peak(opeak)
`endif
  );

  envelope_tracker_mc #(.DATA_WIDTH(16), .NUM_CH(3), .FRAC_BITS(8), .SHIFT_W(4)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid2), .i_ch(ch2), .i_Re(re), .i_Im(im),
    .i_attack_shift(atk), .i_release_shift(rel), .i_ch_clear(clr2),
    .o_valid(ov2), .o_ch(och2), .o_env(oenv2)
`ifdef ENVELOPE_PEAK_HOLD_EN
    , .o_peak(opeak2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [15:0] r, input logic [15:0] i);
    valid = v;
    ch    = c;
    re    = r;
    im    = i;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 2'd0, 16'd0, 16'd0);
    repeat (3) tick();
    total_cnt++; if (ov !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", ov); else pass_cnt++;
    total_cnt++; if (och !== 2'd0) $display("FAIL reset_ch got=%0d exp=0", och); else pass_cnt++;
    total_cnt++; if (oenv !== 16'd0) $display("FAIL reset_env got=%0d exp=0", oenv); else pass_cnt++;
`ifdef ENVELOPE_PEAK_HOLD_EN
    total_cnt++; if (opeak !== 16'd0) $display("FAIL reset_peak got=%0d exp=0", opeak); else pass_cnt++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_single();
    atk = 4'd0;
    drive(1'b1, 2'd0, 16'd1000, 16'd0);
    tick();
    drive(1'b0, 2'd0, 16'd0, 16'd0);
    tick();
    total_cnt++; if (ov !== 1'b0) $display("FAIL single_early got=%0b exp=0", ov); else pass_cnt++;
    tick();
    total_cnt++; if (ov !== 1'b1) $display("FAIL single_valid got=%0b exp=1", ov); else pass_cnt++;
    total_cnt++; if (och !== 2'd0) $display("FAIL single_ch got=%0d exp=0", och); else pass_cnt++;
    total_cnt++; if (oenv !== 16'd1000) $display("FAIL single_env got=%0d exp=1000", oenv); else pass_cnt++;
    tick();
    total_cnt++; if (ov !== 1'b0) $display("FAIL single_pulse got=%0b exp=0", ov); else pass_cnt++;
    total_cnt++; if (oenv !== 16'd1000) $display("FAIL single_hold got=%0d exp=1000", oenv); else pass_cnt++;
  endtask

  task automatic test_full_scale();
    atk = 4'd0;
    drive(1'b1, 2'd0, 16'h8000, 16'h8000);
    tick();
    drive(1'b0, 2'd0, 16'd0, 16'd0);
    repeat (2) tick();
    total_cnt++; if (ov !== 1'b1) $display("FAIL fullscale_valid got=%0b exp=1", ov); else pass_cnt++;
    total_cnt++; if (oenv !== 16'd45056) $display("FAIL fullscale_env got=%0d exp=45056", oenv); else pass_cnt++;
`ifdef ENVELOPE_PEAK_HOLD_EN
    total_cnt++; if (opeak !== 16'd45056) $display("FAIL fullscale_peak got=%0d exp=45056", opeak); else pass_cnt++;
`endif
    tick();
  endtask

  task automatic test_attack_rate();
    logic [15:0] exp_env [4];
    exp_env[0] = 16'd500;
    exp_env[1] = 16'd750;
    exp_env[2] = 16'd875;
    exp_env[3] = 16'd937;
    atk = 4'd1;
    for (int cyc = 0; cyc < 7; cyc++) begin
      if (cyc < 4) drive(1'b1, 2'd2, 16'd1000, 16'd0);
      else         drive(1'b0, 2'd0, 16'd0, 16'd0);
      tick();
      if (cyc >= 2 && cyc <= 5) begin
        total_cnt++; if (ov !== 1'b1) $display("FAIL attack_valid[%0d] got=%0b exp=1", cyc-2, ov); else pass_cnt++;
        total_cnt++; if (och !== 2'd2) $display("FAIL attack_ch[%0d] got=%0d exp=2", cyc-2, och); else pass_cnt++;
        total_cnt++; if (oenv !== exp_env[cyc-2]) $display("FAIL attack_env[%0d] got=%0d exp=%0d", cyc-2, oenv, exp_env[cyc-2]); else pass_cnt++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_ch;
    logic [15:0] exp_env;
    atk = 4'd0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc >= 6)          drive(1'b0, 2'd0, 16'd0, 16'd0);
      else if (cyc % 2 == 0) drive(1'b1, 2'd0, 16'd0, 16'hFC18);
      else                   drive(1'b1, 2'd1, 16'd0, 16'd0);
      tick();
      if (cyc >= 2) begin
        exp_ch  = ((cyc - 2) % 2 == 0) ? 2'd0 : 2'd1;
        exp_env = ((cyc - 2) % 2 == 0) ? 16'd1000 : 16'd0;
        total_cnt++; if (ov !== 1'b1) $display("FAIL b2b_valid[%0d] got=%0b exp=1", cyc-2, ov); else pass_cnt++;
        total_cnt++; if (och !== exp_ch) $display("FAIL b2b_ch[%0d] got=%0d exp=%0d", cyc-2, och, exp_ch); else pass_cnt++;
        total_cnt++; if (oenv !== exp_env) $display("FAIL b2b_env[%0d] got=%0d exp=%0d", cyc-2, oenv, exp_env); else pass_cnt++;
      end
    end
    tick();
  endtask

  task automatic test_clear_release();
    logic [15:0] exp_env [4];
    logic [15:0] exp_peak [4];
    exp_env[0] = 16'd1000; exp_peak[0] = 16'd1000;
    exp_env[1] = 16'd0;    exp_peak[1] = 16'd0;
    exp_env[2] = 16'd400;  exp_peak[2] = 16'd400;
    exp_env[3] = 16'd200;  exp_peak[3] = 16'd400;
    atk = 4'd0;
    rel = 4'd1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      case (cyc)
        0, 1:    drive(1'b1, 2'd3, 16'd1000, 16'd0);
        2:       drive(1'b1, 2'd3, 16'd400, 16'd0);
        3:       drive(1'b1, 2'd3, 16'd0, 16'd0);
        default: drive(1'b0, 2'd0, 16'd0, 16'd0);
      endcase
      // Second ch3 sample (driven at cyc 1) occupies the update stage during cyc 3.
      clr = (cyc == 3) ? 4'b1000 : 4'b0000;
      tick();
      if (cyc >= 2) begin
        total_cnt++; if (ov !== 1'b1) $display("FAIL clr_valid[%0d] got=%0b exp=1", cyc-2, ov); else pass_cnt++;
        total_cnt++; if (oenv !== exp_env[cyc-2]) $display("FAIL clr_env[%0d] got=%0d exp=%0d", cyc-2, oenv, exp_env[cyc-2]); else pass_cnt++;
`ifdef ENVELOPE_PEAK_HOLD_EN
        total_cnt++; if (opeak !== exp_peak[cyc-2]) $display("FAIL clr_peak[%0d] got=%0d exp=%0d", cyc-2, opeak, exp_peak[cyc-2]); else pass_cnt++;
`endif
      end
    end
    clr = 4'b0000;
    rel = 4'd0;
    tick();
  endtask

  task automatic test_invalid_channel();
    atk = 4'd0;
    valid2 = 1'b1;
    ch2    = 2'd3;
    re     = 16'd1000;
    im     = 16'd0;
    tick();
    valid2 = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      tick();
      total_cnt++; if (ov2 !== 1'b0) $display("FAIL invalid_ch_valid[%0d] got=%0b exp=0", cyc, ov2); else pass_cnt++;
    end
    valid2 = 1'b1;
    ch2    = 2'd2;
    tick();
    valid2 = 1'b0;
    repeat (2) tick();
    total_cnt++; if (ov2 !== 1'b1) $display("FAIL lastch_valid got=%0b exp=1", ov2); else pass_cnt++;
    total_cnt++; if (och2 !== 2'd2) $display("FAIL lastch_ch got=%0d exp=2", och2); else pass_cnt++;
    total_cnt++; if (oenv2 !== 16'd1000) $display("FAIL lastch_env got=%0d exp=1000", oenv2); else pass_cnt++;
    re = 16'd0;
    tick();
  endtask

  task automatic test_reset_midstream();
    atk = 4'd1;
    drive(1'b1, 2'd0, 16'd2000, 16'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 2'd0, 16'd0, 16'd0);
    total_cnt++; if (ov !== 1'b0) $display("FAIL midrst_valid_after_rst got=%0b exp=0", ov); else pass_cnt++;
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      total_cnt++; if (ov !== 1'b0) $display("FAIL midrst_flush[%0d] got=%0b exp=0", cyc, ov); else pass_cnt++;
    end
    drive(1'b1, 2'd0, 16'd1000, 16'd0);
    tick();
    drive(1'b0, 2'd0, 16'd0, 16'd0);
    repeat (2) tick();
    total_cnt++; if (ov !== 1'b1) $display("FAIL midrst_new_valid got=%0b exp=1", ov); else pass_cnt++;
    total_cnt++; if (oenv !== 16'd500) $display("FAIL midrst_new_env got=%0d exp=500", oenv); else pass_cnt++;
`ifdef ENVELOPE_PEAK_HOLD_EN
    total_cnt++; if (opeak !== 16'd1000) $display("FAIL midrst_new_peak got=%0d exp=1000", opeak); else pass_cnt++;
`endif
    tick();
  endtask

  initial begin
    rst    = 1'b1;
    valid  = 1'b0;
    ch     = 2'd0;
    re     = 16'd0;
    im     = 16'd0;
    atk    = 4'd0;
    rel    = 4'd0;
    clr    = 4'd0;
    valid2 = 1'b0;
    ch2    = 2'd0;
    clr2   = 3'd0;
    test_reset();
    test_single();
    test_full_scale();
    test_attack_rate();
    test_back_to_back();
    test_clear_release();
    test_invalid_channel();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
